// File: rtl/bcd_modn_counter.sv
// Modulo-N up/down counter that keeps its value in packed BCD digits.
// Supports clear, checked parallel load, wrap and load-error pulses, and a combinational terminal count.
module bcd_modn_counter #(
    parameter int DIGITS  = 2,
    parameter int MOD_VAL = 60
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] res;
        int           rem;
        res = '0;
        rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(rem % 10);
            rem           = rem / 10;
        end
        return res;
    endfunction

    localparam logic [W-1:0] C_MAX = to_bcd(MOD_VAL - 1);

    logic [W-1:0] r_count;
    logic         r_wrap;
    logic         r_load_err;

    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic         w_load_ok;
    logic         w_at_max;
    logic         w_at_zero;
    logic         w_tc;

    // Valid BCD vectors order the same way as plain unsigned numbers,
    // so the range check is a direct compare once every digit is legal.
    always_comb begin
        w_load_ok = (load_val <= C_MAX);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        logic cy;
        logic bw;
        w_inc = r_count;
        w_dec = r_count;
        cy    = 1'b1;
        bw    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    cy              = 1'b0;
                end
            end
            if (bw) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    bw              = 1'b0;
                end
            end
        end
    end

    assign w_at_max  = (r_count == C_MAX);
    assign w_at_zero = (r_count == '0);
    assign w_tc      = en && !clr && !load && ((up && w_at_max) || (!up && w_at_zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (clr) begin
                r_count <= '0;
            end else if (load) begin
                if (w_load_ok) begin
                    r_count <= load_val;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (en) begin
                if (w_tc) begin
                    r_count <= up ? '0 : C_MAX;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= up ? w_inc : w_dec;
                end
            end
        end
    end

    assign count    = r_count;
    assign tc       = w_tc;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule
